// File: rtl/aes_key_sched_ctrl.sv
// aes_key_sched_ctrl
// Owns the load/step control of a 128-bit AES key-expansion unit. It loads a
// cipher key, steps the unit ten times, and captures the eleven round keys.
// It then serves those round keys to the cipher core through a registered read port.
// Build option: define AES_KS_ZEROIZE_EN to add a zeroize input. Zeroize wipes
// all stored key material and returns the controller to IDLE.
module aes_key_sched_ctrl #(
  parameter int KEY_W  = 128,
  parameter int NUM_RK = 11,
  parameter int AW     = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
`ifdef AES_KS_ZEROIZE_EN
  input  logic             zeroize,
`endif
  input  logic             key_valid,
  output logic             key_ready,
  input  logic [KEY_W-1:0] key_in,
  output logic             ks_load,
  output logic [KEY_W-1:0] ks_key,
  output logic [3:0]       ks_rcon_idx,
  input  logic [KEY_W-1:0] ks_w,
  output logic             busy,
  output logic             keys_ready,
  input  logic             rk_rd_en,
  input  logic [AW-1:0]    rk_rd_addr,
  output logic             rk_rd_valid,
  output logic [KEY_W-1:0] rk_rd_data,
  output logic             rk_rd_err
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EXPAND,
    ST_FINAL,
    ST_READY
  } state_t;

  localparam logic [3:0]    LAST_STEP = 4'd9;
  localparam logic [AW-1:0] LAST_RK   = AW'(NUM_RK - 1);

  state_t           state;
  logic [KEY_W-1:0] rk_mem [NUM_RK];
  logic             zero_hit;

`ifdef AES_KS_ZEROIZE_EN
  assign zero_hit = zeroize;
`else
  assign zero_hit = 1'b0;
`endif

  // Sequencer: the step counter doubles as the Rcon index shown to the expander,
  // and ks_load is dropped only while in EXPAND so the expander's own index wraps cleanly.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= ST_IDLE;
      key_ready   <= 1'b1;
      ks_load     <= 1'b1;
      ks_key      <= '0;
      ks_rcon_idx <= 4'd0;
      busy        <= 1'b0;
      keys_ready  <= 1'b0;
    end else if (zero_hit) begin
      state       <= ST_IDLE;
      key_ready   <= 1'b1;
      ks_load     <= 1'b1;
      ks_key      <= '0;
      ks_rcon_idx <= 4'd0;
      busy        <= 1'b0;
      keys_ready  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_READY: begin
          if (key_valid) begin
            ks_key     <= key_in;
            keys_ready <= 1'b0;
            key_ready  <= 1'b0;
            busy       <= 1'b1;
            state      <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          ks_load     <= 1'b0;
          ks_rcon_idx <= 4'd0;
          state       <= ST_EXPAND;
        end
        ST_EXPAND: begin
          if (ks_rcon_idx == LAST_STEP) begin
            ks_load     <= 1'b1;
            ks_rcon_idx <= 4'd0;
            state       <= ST_FINAL;
          end else begin
            ks_rcon_idx <= ks_rcon_idx + 4'd1;
          end
        end
        ST_FINAL: begin
          keys_ready <= 1'b1;
          busy       <= 1'b0;
          key_ready  <= 1'b1;
          state      <= ST_READY;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Round-key storage: each expansion cycle captures the expander's current round
  // key; the storage has no reset because keys_ready gates every read.
  always_ff @(posedge CLK) begin
    if (zero_hit) begin
      for (int i = 0; i < NUM_RK; i++) begin
        rk_mem[i] <= '0;
      end
    end else if (state == ST_EXPAND) begin
      rk_mem[ks_rcon_idx] <= ks_w;
    end else if (state == ST_FINAL) begin
      rk_mem[NUM_RK-1] <= ks_w;
    end
  end

  // Registered read port: answers one cycle after the request and returns zero
  // with an error flag for out-of-range addresses or keys that are not yet valid.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rk_rd_valid <= 1'b0;
      rk_rd_data  <= '0;
      rk_rd_err   <= 1'b0;
    end else begin
      rk_rd_valid <= rk_rd_en;
      if (rk_rd_en && !zero_hit && keys_ready && (rk_rd_addr <= LAST_RK)) begin
        rk_rd_data <= rk_mem[rk_rd_addr];
        rk_rd_err  <= 1'b0;
      end else begin
        rk_rd_data <= '0;
        rk_rd_err  <= rk_rd_en;
      end
    end
  end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// tb_aes_key_sched_ctrl
// Self-checking bench for aes_key_sched_ctrl. A stand-in key expander drives
// ks_w. A cycle-count reference model predicts every output each cycle, and the
// model's round keys come from the FIPS-197 word recurrence.
// Define AES_KS_ZEROIZE_EN to also exercise the zeroize input.
module tb_aes_key_sched_ctrl;

  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] RK1_FIPS  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] RK10_FIPS = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEY_C1    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] RK10_C1   = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic         CLK;
  logic         RST_N;
  logic         zeroize;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] key_in;
  logic         ks_load;
  logic [127:0] ks_key;
  logic [3:0]   ks_rcon_idx;
  logic [127:0] ks_w;
  logic         busy;
  logic         keys_ready;
  logic         rk_rd_en;
  logic [3:0]   rk_rd_addr;
  logic         rk_rd_valid;
  logic [127:0] rk_rd_data;
  logic         rk_rd_err;

  int total = 0;
  int bad   = 0;
  logic chk_en;

  aes_key_sched_ctrl #(.KEY_W(128), .NUM_RK(11), .AW(4)) dut (
    .CLK(CLK),
    .RST_N(RST_N),
`ifdef AES_KS_ZEROIZE_EN
    .zeroize(zeroize),
`endif
    .key_valid(key_valid),
    .key_ready(key_ready),
    .key_in(key_in),
    .ks_load(ks_load),
    .ks_key(ks_key),
    .ks_rcon_idx(ks_rcon_idx),
    .ks_w(ks_w),
    .busy(busy),
    .keys_ready(keys_ready),
    .rk_rd_en(rk_rd_en),
    .rk_rd_addr(rk_rd_addr),
    .rk_rd_valid(rk_rd_valid),
    .rk_rd_data(rk_rd_data),
    .rk_rd_err(rk_rd_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // GF(2^8) arithmetic for the AES S-box
  logic [7:0] sbox_tab [0:255];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int k);
    logic [15:0] t;
    t = {x, x};
    return t[15-k -: 8];
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h00;
    for (int b = 1; b < 256; b++) begin
      if (gmul(a, 8'(b)) == 8'h01) inv = 8'(b);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input int i);
    logic [7:0] r;
    r = 8'h01;
    for (int j = 0; j < i; j++) r = xtime(r);
    return r;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
  endfunction

  // One round of the stand-in expander: next 4-word round key from the current one
  function automatic logic [127:0] next_rk(input logic [127:0] w, input int idx);
    logic [31:0] t, n0, n1, n2, n3;
    t  = sub_word({w[23:0], w[31:24]}) ^ {rcon(idx), 24'h0};
    n0 = w[127:96] ^ t;
    n1 = w[95:64] ^ n0;
    n2 = w[63:32] ^ n1;
    n3 = w[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Reference: full FIPS-197 word expansion, rk r at bits [r*128 +: 128]
  function automatic logic [1407:0] ref_expand(input logic [127:0] key);
    logic [31:0]   w [0:43];
    logic [31:0]   t;
    logic [1407:0] r;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) t = sub_word({t[23:0], t[31:24]}) ^ {rcon(i/4 - 1), 24'h0};
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k < 11; k++) r[k*128 +: 128] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    return r;
  endfunction

  function automatic logic [127:0] rand_key();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    for (int a = 0; a < 256; a++) sbox_tab[a] = sbox_calc(8'(a));
  end

  // Stand-in expander: loads ks_key when ks_load=1, otherwise advances one round with its own Rcon index
  logic [127:0] exp_w;
  int           exp_idx;
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      exp_w   <= '0;
      exp_idx <= 0;
    end else if (ks_load) begin
      exp_w <= ks_key;
    end else begin
      exp_w   <= next_rk(exp_w, exp_idx);
      exp_idx <= (exp_idx + 1) % 10;
    end
  end
  assign ks_w = exp_w;

  // Reference model: m_cyc counts cycles since a key was accepted (0 = not expanding)
  int            m_cyc;
  logic          m_kr;
  logic [127:0]  m_kskey;
  logic [127:0]  m_keys [0:10];
  logic          m_rv;
  logic          m_rerr;
  logic [127:0]  m_rdata;
  logic [1407:0] m_exp;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_cyc   = 0;
      m_kr    = 1'b0;
      m_kskey = '0;
      m_rv    = 1'b0;
      m_rerr  = 1'b0;
      m_rdata = '0;
    end else begin
      m_rv = rk_rd_en;
      if (rk_rd_en) begin
        if (zeroize || !m_kr || rk_rd_addr > 4'd10) begin
          m_rerr  = 1'b1;
          m_rdata = '0;
        end else begin
          m_rerr  = 1'b0;
          m_rdata = m_keys[rk_rd_addr];
        end
      end
      if (zeroize) begin
        m_cyc   = 0;
        m_kr    = 1'b0;
        m_kskey = '0;
        for (int i = 0; i < 11; i++) m_keys[i] = '0;
      end else if (m_cyc == 0) begin
        if (key_valid) begin
          m_cyc   = 1;
          m_kr    = 1'b0;
          m_kskey = key_in;
          m_exp   = ref_expand(key_in);
          for (int i = 0; i < 11; i++) m_keys[i] = m_exp[i*128 +: 128];
        end
      end else if (m_cyc == 12) begin
        m_cyc = 0;
        m_kr  = 1'b1;
      end else begin
        m_cyc = m_cyc + 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, sampled mid-cycle
  always @(negedge CLK) begin
    if (chk_en) begin
      checkOutput("key_ready", key_ready, m_cyc == 0);
      checkOutput("busy", busy, m_cyc != 0);
      checkOutput("keys_ready", keys_ready, m_kr);
      checkOutput("ks_load", ks_load, !(m_cyc >= 2 && m_cyc <= 11));
      checkOutput("ks_rcon_idx", ks_rcon_idx, (m_cyc >= 2 && m_cyc <= 11) ? m_cyc - 2 : 0);
      checkOutput("ks_key", ks_key, m_kskey);
      checkOutput("rk_rd_valid", rk_rd_valid, m_rv);
      if (m_rv) begin
        checkOutput("rk_rd_data", rk_rd_data, m_rdata);
        checkOutput("rk_rd_err", rk_rd_err, m_rerr);
      end
    end
  end

  // Drive one cycle of inputs, then move to just after the next rising edge
  task automatic applyStimulus(input logic kv, input logic [127:0] k, input logic re, input logic [3:0] ra);
    key_valid  = kv;
    key_in     = k;
    rk_rd_en   = re;
    rk_rd_addr = ra;
    @(posedge CLK);
    #2;
  endtask

  task automatic waitKeysReady(input int limit, output int n);
    n = 0;
    while (keys_ready !== 1'b1 && n < limit) begin
      applyStimulus(1'b0, '0, 1'b0, 4'd0);
      n++;
    end
    checkOutput("keys_ready_wait", keys_ready, 1'b1);
  endtask

  int            n_wait;
  int            vcount;
  logic [1407:0] pin;

  initial begin
    RST_N      = 1'b0;
    zeroize    = 1'b0;
    key_valid  = 1'b0;
    key_in     = '0;
    rk_rd_en   = 1'b0;
    rk_rd_addr = 4'd0;
    chk_en     = 1'b0;
    repeat (2) @(posedge CLK);
    #2;
    chk_en = 1'b1;

    $display("[TB] reset values");
    checkOutput("rst_key_ready", key_ready, 1'b1);
    checkOutput("rst_ks_load", ks_load, 1'b1);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_keys_ready", keys_ready, 1'b0);
    checkOutput("rst_rd_valid", rk_rd_valid, 1'b0);
    checkOutput("rst_ks_key", ks_key, '0);

    $display("[TB] model pins");
    checkOutput("model_sbox_00", sbox_tab[0], 8'h63);
    checkOutput("model_sbox_53", sbox_tab[8'h53], 8'hed);
    pin = ref_expand(FIPS_KEY);
    checkOutput("model_fips_rk1", pin[1*128 +: 128], RK1_FIPS);
    checkOutput("model_fips_rk10", pin[10*128 +: 128], RK10_FIPS);
    pin = ref_expand(KEY_C1);
    checkOutput("model_c1_rk10", pin[10*128 +: 128], RK10_C1);

    RST_N = 1'b1;
    applyStimulus(1'b0, '0, 1'b1, 4'd0);
    checkOutput("early_read_err", rk_rd_err, 1'b1);

    $display("[TB] FIPS key and latency");
    applyStimulus(1'b1, FIPS_KEY, 1'b0, 4'd0);
    waitKeysReady(40, n_wait);
    checkOutput("accept_latency", n_wait, 12);

    $display("[TB] back-to-back reads");
    vcount = 0;
    for (int a = 0; a <= 10; a++) begin
      applyStimulus(1'b0, '0, 1'b1, 4'(a));
      if (rk_rd_valid) vcount++;
      if (a == 1) checkOutput("fips_rk1", rk_rd_data, RK1_FIPS);
      if (a == 10) checkOutput("fips_rk10", rk_rd_data, RK10_FIPS);
    end
    checkOutput("read_pulses", vcount, 11);
    applyStimulus(1'b0, '0, 1'b1, 4'd11);
    checkOutput("addr11_err", rk_rd_err, 1'b1);
    checkOutput("addr11_data", rk_rd_data, '0);
    applyStimulus(1'b0, '0, 1'b1, 4'd15);
    checkOutput("addr15_err", rk_rd_err, 1'b1);
    checkOutput("addr15_data", rk_rd_data, '0);
    applyStimulus(1'b0, '0, 1'b0, 4'd0);
    checkOutput("rd_valid_drop", rk_rd_valid, 1'b0);

    $display("[TB] second key, key_valid held while busy");
    applyStimulus(1'b1, KEY_C1, 1'b1, 4'd10);
    checkOutput("old_key_on_accept", rk_rd_data, RK10_FIPS);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, rand_key(), 1'b0, 4'd0);
    waitKeysReady(20, n_wait);
    checkOutput("held_key_ignored", ks_key, KEY_C1);
    applyStimulus(1'b0, '0, 1'b1, 4'd10);
    checkOutput("c1_rk10", rk_rd_data, RK10_C1);
    applyStimulus(1'b0, '0, 1'b1, 4'd0);
    checkOutput("c1_rk0", rk_rd_data, KEY_C1);
    applyStimulus(1'b1, rand_key(), 1'b0, 4'd0);
    waitKeysReady(20, n_wait);
    for (int a = 0; a <= 10; a++) applyStimulus(1'b0, '0, 1'b1, 4'(a));

    $display("[TB] reset during expansion");
    applyStimulus(1'b1, rand_key(), 1'b0, 4'd0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, 1'b0, 4'd0);
    checkOutput("at_step5", ks_rcon_idx, 4'd5);
    RST_N = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, 4'd0);
    checkOutput("midrst_keys_ready", keys_ready, 1'b0);
    checkOutput("midrst_key_ready", key_ready, 1'b1);
    RST_N = 1'b1;
    applyStimulus(1'b0, '0, 1'b1, 4'd2);
    checkOutput("midrst_read_err", rk_rd_err, 1'b1);
    applyStimulus(1'b1, FIPS_KEY, 1'b0, 4'd0);
    waitKeysReady(20, n_wait);
    applyStimulus(1'b0, '0, 1'b1, 4'd1);
    checkOutput("reload_rk1", rk_rd_data, RK1_FIPS);

`ifdef AES_KS_ZEROIZE_EN
    $display("[TB] zeroize");
    zeroize = 1'b1;
    applyStimulus(1'b1, rand_key(), 1'b1, 4'd3);
    zeroize = 1'b0;
    checkOutput("zero_rd_data", rk_rd_data, '0);
    checkOutput("zero_rd_err", rk_rd_err, 1'b1);
    checkOutput("zero_ks_key", ks_key, '0);
    applyStimulus(1'b0, '0, 1'b1, 4'd3);
    checkOutput("zero_rk3_err", rk_rd_err, 1'b1);
    applyStimulus(1'b1, FIPS_KEY, 1'b0, 4'd0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, '0, 1'b0, 4'd0);
    zeroize = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 4'd0);
    zeroize = 1'b0;
    for (int i = 0; i < 14; i++) applyStimulus(1'b0, '0, 1'b0, 4'd0);
    checkOutput("zero_exp_keys_ready", keys_ready, 1'b0);
    checkOutput("zero_exp_busy", busy, 1'b0);
    RST_N = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, 4'd0);
    RST_N = 1'b1;
`endif

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 15) == 0, rand_key(), 1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 15)));
    end
    applyStimulus(1'b0, '0, 1'b0, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
